// File: rtl/mul_booth_seq.sv
// rtl/mul_booth_seq.sv - Sequenced 32x32 signed radix-4 Booth multiplier producing HI/LO.
// Optional MUL_ZERO_SKIP_EN: a zero operand completes in one cycle with a zero result.

module add_64_16_term (
  input  logic [15:0][63:0] terms,
  output logic [63:0]       sum
);
  // Modulo 2^64 accumulation; the carry out of bit 63 is intentionally dropped.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum = sum + terms[i];
    end
  end
endmodule

module mul_booth_seq #(
  parameter int REG_TERMS = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {S_IDLE, S_ENC, S_SUM, S_DONE} state_t;

  state_t state_q, state_d;
  logic [31:0] ra_q, ra_d, rb_q, rb_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [15:0][63:0] pp_comb, pp_sum;
  logic [63:0] sum;
  logic zero_skip;

`ifdef MUL_ZERO_SKIP_EN
  assign zero_skip = (a == 32'd0) || (b == 32'd0);
`else
  assign zero_skip = 1'b0;
`endif

  // Each term is a full 64-bit signed value, so negation needs no separate correction term.
  always_comb begin : booth_enc
    logic [32:0] rb_ext;
    logic [63:0] base;
    logic [63:0] mag;
    logic [2:0]  trip;
    rb_ext = {rb_q, 1'b0};
    base   = {{32{ra_q[31]}}, ra_q};
    for (int i = 0; i < 16; i++) begin
      trip = rb_ext[2*i +: 3];
      case (trip)
        3'b001, 3'b010, 3'b101, 3'b110: mag = base;
        3'b011, 3'b100:                 mag = base << 1;
        default:                        mag = '0;
      endcase
      if (trip[2]) mag = ~mag + 64'd1;
      pp_comb[i] = mag << (2 * i);
    end
  end

  if (REG_TERMS != 0) begin : g_reg
    logic [15:0][63:0] pp_q, pp_d;
    always_comb pp_d = (state_q == S_ENC) ? pp_comb : pp_q;
    always_ff @(posedge clk) begin
      if (!clr) pp_q <= '0;
      else      pp_q <= pp_d;
    end
    assign pp_sum = pp_q;
  end else begin : g_comb
    assign pp_sum = pp_comb;
  end

  add_64_16_term u_add (
    .terms (pp_sum),
    .sum   (sum)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          ra_d = a;
          rb_d = b;
          if (zero_skip) begin
            state_d = S_DONE;
            hi_d    = '0;
            lo_d    = '0;
          end else begin
            state_d = (REG_TERMS != 0) ? S_ENC : S_SUM;
          end
        end
      end
      S_ENC: state_d = S_SUM;
      S_SUM: begin
        {hi_d, lo_d} = sum;
        state_d      = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_ENC) || (state_q == S_SUM);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mul_booth_seq.sv
// tb/tb_mul_booth_seq.sv - Scoreboard bench for mul_booth_seq (default REG_TERMS=1).

module tb_mul_booth_seq;
  localparam int LAT = 3;
`ifdef MUL_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = LAT;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;
  logic [63:0] sb[$];

  mul_booth_seq dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    sx = $signed({{32{x[31]}}, x});
    sy = $signed({{32{y[31]}}, y});
    return 64'(sx * sy);
  endfunction

  always @(negedge clk) begin
    if (clr && done === 1'b1) begin
      if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
      else check("result", {hi, lo}, sb.pop_front());
    end
  end

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v);
    a = ta;
    b = tb_v;
    start = 1'b1;
    sb.push_back(prod(ta, tb_v));
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int  n;
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 12) begin
      if (busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy"}, {63'd0, bad}, 64'd0);
  endtask

  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v, input int exp_lat);
    issue(ta, tb_v);
    wait_done(tag, exp_lat);
  endtask

  initial begin
    logic bad;
    clr = 1'b0; start = 1'b1; a = 32'd5; b = 32'd5;
    repeat (2) @(negedge clk);
    check("rst_state", {busy, done, hi, lo}, 66'd0);
    clr = 1'b1; start = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    check("rst_no_op", {63'd0, bad}, 64'd0);

    do_op("basic", 32'd7, 32'd6, LAT);
    check("basic_val", {hi, lo}, 64'h0000_0000_0000_002A);
    do_op("neg_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
    check("neg_neg_val", {hi, lo}, 64'h0000_0000_0000_0001);
    do_op("max_neg", 32'h7FFF_FFFF, 32'hFFFF_FFFF, LAT);
    check("max_neg_val", {hi, lo}, 64'hFFFF_FFFF_8000_0001);
    do_op("min_min", 32'h8000_0000, 32'h8000_0000, LAT);
    check("min_min_val", {hi, lo}, 64'h4000_0000_0000_0000);

    // start while busy must be ignored; start during DONE is taken back-to-back
    issue(32'd7, 32'd6);
    @(negedge clk);
    a = 32'd3; b = 32'd3; start = 1'b1;
    check("hs_busy1", {63'd0, busy}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    check("hs_busy2", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("hs_done", {63'd0, done}, 64'd1);
    check("hs_val", {hi, lo}, 64'd42);
    issue(32'd3, 32'd3);
    wait_done("b2b", LAT);
    check("b2b_val", {hi, lo}, 64'd9);
    @(negedge clk);
    check("done_pulse", {63'd0, done}, 64'd0);
    check("hold_val", {hi, lo}, 64'd9);

    // reset during SUM aborts the operation
    issue(32'd11, 32'd13);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    sb.delete();
    check("abort_state", {busy, done, hi, lo}, 66'd0);
    clr = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0) bad = 1'b1;
    end
    check("abort_no_done", {63'd0, bad}, 64'd0);
    do_op("post_abort", 32'hFFFF_FFFD, 32'd5, LAT);

    do_op("zero", 32'd0, 32'h1234_5678, ZLAT);
    check("zero_val", {hi, lo}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_op("rand", $urandom, $urandom, LAT);
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
